// File: rtl/dp_ram_wrapper.sv
// True dual-port synchronous RAM with registered read ports and old-data read-during-write.
// Port A wins a same-address write collision; out-of-range addresses are ignored on write, read as 0.
module dp_ram_wrapper #(
    parameter int unsigned AWIDTH    = 5,
    parameter int unsigned NUM_WORDS = 32,
    parameter int unsigned DWIDTH    = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [AWIDTH-1:0] address_a,
    input  logic [DWIDTH-1:0] data_a,
    input  logic              wren_a,
    input  logic              rden_a,
    output logic [DWIDTH-1:0] out_a,
    input  logic [AWIDTH-1:0] address_b,
    input  logic [DWIDTH-1:0] data_b,
    input  logic              wren_b,
    input  logic              rden_b,
    output logic [DWIDTH-1:0] out_b
);

    // Zero-initialised for simulation; reset never touches the array.
    logic [DWIDTH-1:0] ram [NUM_WORDS] = '{default: '0};

    logic in_range_a;
    logic in_range_b;

    assign in_range_a = 32'(address_a) < NUM_WORDS;
    assign in_range_b = 32'(address_b) < NUM_WORDS;

    // Port B is written first so port A's nonblocking write lands last on a collision.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (wren_b && in_range_b) begin
                ram[address_b] <= data_b;
            end
            if (wren_a && in_range_a) begin
                ram[address_a] <= data_a;
            end
        end
    end

    // Reads sample the array before this edge's writes take effect (old data).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_a <= '0;
            out_b <= '0;
        end else begin
            if (rden_a) begin
                out_a <= in_range_a ? ram[address_a] : '0;
            end
            if (rden_b) begin
                out_b <= in_range_b ? ram[address_b] : '0;
            end
        end
    end

endmodule

// File: tb/tb_dp_ram_wrapper.sv
// Scoreboard bench for dp_ram_wrapper: directed spec scenarios followed by randomized traffic
// checked against an array-based model of the RAM.
module tb_dp_ram_wrapper;

    localparam int unsigned AW = 5;
    localparam int unsigned NW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [AW-1:0] address_a = '0;
    logic [DW-1:0] data_a = '0;
    logic          wren_a = 1'b0;
    logic          rden_a = 1'b0;
    logic [DW-1:0] out_a;
    logic [AW-1:0] address_b = '0;
    logic [DW-1:0] data_b = '0;
    logic          wren_b = 1'b0;
    logic          rden_b = 1'b0;
    logic [DW-1:0] out_b;

    dp_ram_wrapper #(
        .AWIDTH    (AW),
        .NUM_WORDS (NW),
        .DWIDTH    (DW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .address_a (address_a),
        .data_a    (data_a),
        .wren_a    (wren_a),
        .rden_a    (rden_a),
        .out_a     (out_a),
        .address_b (address_b),
        .data_b    (data_b),
        .wren_b    (wren_b),
        .rden_b    (rden_b),
        .out_b     (out_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            tag;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;

    exp_t          sb[$];
    int            edge_cnt = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    logic [DW-1:0] mdl_ram [NW];
    logic [DW-1:0] mdl_a;
    logic [DW-1:0] mdl_b;

    always @(posedge clk) edge_cnt++;

    // Monitor: compare both outputs for every edge that has already happened.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag <= edge_cnt) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if (out_a !== e.a) begin
                n_fail++;
                $display("FAIL out_a edge %0d: got %h, expected %h", e.tag, out_a, e.a);
            end
            n_tests++;
            if (out_b !== e.b) begin
                n_fail++;
                $display("FAIL out_b edge %0d: got %h, expected %h", e.tag, out_b, e.b);
            end
        end
    end

    // Apply one cycle of stimulus and push the model's view of the outputs after that edge.
    task automatic drive(input logic rst, input logic wa, input logic ra,
                         input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic wb, input logic rb,
                         input logic [AW-1:0] ab, input logic [DW-1:0] db);
        exp_t e;
        @(posedge clk);
        #1;
        resetn    = rst;
        wren_a    = wa;
        rden_a    = ra;
        address_a = aa;
        data_a    = da;
        wren_b    = wb;
        rden_b    = rb;
        address_b = ab;
        data_b    = db;
        if (!rst) begin
            mdl_a = '0;
            mdl_b = '0;
        end else begin
            if (ra) mdl_a = (int'(aa) < NW) ? mdl_ram[aa] : '0;
            if (rb) mdl_b = (int'(ab) < NW) ? mdl_ram[ab] : '0;
            if (wb && int'(ab) < NW) mdl_ram[ab] = db;
            if (wa && int'(aa) < NW) mdl_ram[aa] = da;
        end
        e.tag = edge_cnt + 1;
        e.a   = mdl_a;
        e.b   = mdl_b;
        sb.push_back(e);
    endtask

    // Override the most recent expectation with a literal value from the scenario.
    task automatic pin_a(input logic [DW-1:0] v);
        sb[sb.size()-1].a = v;
    endtask

    task automatic pin_b(input logic [DW-1:0] v);
        sb[sb.size()-1].b = v;
    endtask

    initial begin
        for (int i = 0; i < int'(NW); i++) mdl_ram[i] = '0;
        mdl_a = '0;
        mdl_b = '0;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        pin_a(0);
        pin_b(0);

        // Write A, read B, then hold with rden_b low.
        drive(1, 1, 0, 3, 32'hDEADBEEF, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 3, 0);
        pin_b(32'hDEADBEEF);
        drive(1, 0, 0, 0, 0, 0, 0, 17, 0);
        pin_b(32'hDEADBEEF);
        drive(1, 0, 0, 0, 0, 0, 0, 4, 0);
        pin_b(32'hDEADBEEF);

        // Mixed-port read-during-write returns old data.
        drive(1, 1, 0, 5, 32'h22222222, 0, 0, 0, 0);
        drive(1, 1, 0, 5, 32'h11111111, 0, 1, 5, 0);
        pin_b(32'h22222222);
        drive(1, 0, 0, 0, 0, 0, 1, 5, 0);
        pin_b(32'h11111111);

        // Same-port read-during-write returns old data.
        drive(1, 1, 1, 5, 32'h33333333, 0, 0, 0, 0);
        pin_a(32'h11111111);

        // Reset keeps memory, suppresses writes and zeroes outputs.
        drive(1, 1, 0, 7, 32'hA5A5A5A5, 0, 0, 0, 0);
        drive(0, 1, 1, 7, 32'h0BADF00D, 1, 1, 7, 32'h0BADF00D);
        pin_a(0);
        pin_b(0);
        drive(1, 0, 1, 7, 0, 0, 1, 7, 0);
        pin_a(32'hA5A5A5A5);
        pin_b(32'hA5A5A5A5);

        // Write collision: port A wins.
        drive(1, 1, 0, 9, 32'h1, 1, 0, 9, 32'h2);
        drive(1, 0, 1, 9, 0, 0, 1, 9, 0);
        pin_a(32'h1);
        pin_b(32'h1);

        // Full sweep: write index on A, read back on B.
        for (int i = 0; i < int'(NW); i++) drive(1, 1, 0, AW'(i), DW'(i), 0, 0, 0, 0);
        for (int i = 0; i < int'(NW); i++) begin
            drive(1, 0, 0, 0, 0, 0, 1, AW'(i), 0);
            pin_b(DW'(i));
        end

        // Randomized traffic with a narrow address window half the time to force collisions.
        for (int n = 0; n < 2000; n++) begin
            logic [AW-1:0] ra_addr;
            logic [AW-1:0] rb_addr;
            ra_addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3))
                                                  : AW'($urandom_range(0, NW - 1));
            rb_addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3))
                                                  : AW'($urandom_range(0, NW - 1));
            drive(($urandom_range(0, 63) != 0), 1'($urandom), 1'($urandom), ra_addr, $urandom,
                  1'($urandom), 1'($urandom), rb_addr, $urandom);
        end

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
